floating_pt_oper: RTL and testbench
===================================

FLOATING_PT_OPER -- requirements
Module: floating_pt_oper

Interface
REQ-001 Parameter MANT_W, default 16, SHALL set mantissa width of both operands and the result.
REQ-002 Parameter EXP_W, default 8, SHALL set unsigned exponent width of both operands and the result.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 in_valid  input  1  SHALL mark the operand set as valid this cycle.
REQ-006 a  input  MANT_W  SHALL be operand A unsigned mantissa, integer, no hidden bit.
REQ-007 sign1  input  1  SHALL be operand A sign; 1 = negative.
REQ-008 a1  input  EXP_W  SHALL be operand A exponent; value = (-1)^sign1 * a * 2^a1.
REQ-009 b  input  MANT_W  SHALL be operand B unsigned mantissa.
REQ-010 sign2  input  1  SHALL be operand B sign.
REQ-011 b1  input  EXP_W  SHALL be operand B exponent.
REQ-012 aout  output  MANT_W  SHALL be the result mantissa.
REQ-013 signout  output  1  SHALL be the result sign.
REQ-014 expout  output  EXP_W  SHALL be the result exponent.
REQ-015 out_valid  output  1  SHALL mark aout/signout/expout as a new result.

Function
REQ-016 The block SHALL compute the signed sum A+B; no stall, no backpressure, one operand set accepted per cycle.
REQ-017 Latency SHALL be 2 cycles: stage 1 compare/align, stage 2 add/normalize; out_valid SHALL equal in_valid delayed 2 cycles.
REQ-018 Outputs SHALL hold their last value while out_valid is 0.
REQ-019 Larger operand SHALL be the one with greater exponent; on equal exponents, greater mantissa; on full tie, A.
REQ-020 Smaller mantissa SHALL be right-shifted by the exponent difference, truncated (no rounding, no sticky); difference >= MANT_W SHALL give 0.
REQ-021 Equal signs SHALL add magnitudes; unequal signs SHALL subtract smaller from larger; signout SHALL be the larger operand's sign.
REQ-022 Working exponent SHALL be the larger operand's exponent.
REQ-023 Carry out of bit MANT_W-1: mantissa SHALL shift right 1 (LSB dropped), exponent +1.
REQ-024 Carry with working exponent = 2^EXP_W-1: result SHALL saturate to aout = all ones, expout = 2^EXP_W-1.
REQ-025 No carry and nonzero sum: mantissa SHALL shift left by min(leading-zero count, working exponent), exponent reduced by the same amount; exponent never goes below 0.
REQ-026 Zero sum, including +x plus -x: result SHALL be aout=0, signout=0, expout=0.

Reset
REQ-027 While rst_n=0: all pipeline registers, aout, signout, expout and out_valid SHALL be 0, immediately and independent of clk.
REQ-028 Operands in flight at reset assertion SHALL be discarded; first out_valid after release SHALL come 2 cycles after the first in_valid sampled high.

Structure
REQ-029 A shared package SHALL hold MANT_W/EXP_W defaults and the stage-1 pipeline record type (sign, exponent, large and aligned mantissas, op-is-subtract, valid).
REQ-030 One sub-module fp_lzc SHALL return the leading-zero count of a MANT_W-bit vector (MANT_W for all-zero input); everything else stays in floating_pt_oper.

Verification
REQ-031 a=0,e17,+ ; b=0,e11,+ -> aout=0, signout=0, expout=0.
REQ-032 a=0x0001,e17 ; b=0,e11, both + -> aout=0x8000, expout=2, signout=0.
REQ-033 a=0x030F,e9 ; b=0x000F,e11, both + -> aout=0xD200, expout=3; a=0x000B,e11 ; b=0x0007,e11 -> aout=0x9000, expout=0.
REQ-034 a=0xFFFF,e5 ; b=0x0001,e5, both + -> aout=0x8000, expout=6; same with e255 -> aout=0xFFFF, expout=255.
REQ-035 a=0x0010,e4,- ; b=0x0004,e4,+ -> aout=0x00C0, signout=1, expout=0; a=5,e3,+ ; b=5,e3,- -> all zero.
REQ-036 Back-to-back in_valid for 4 cycles, then rst_n pulsed low mid-stream -> results on consecutive cycles 2 cycles after each input; outputs and out_valid 0 during reset, none for discarded inputs.

Source files
------------

// File: rtl/floating_pt_oper_pkg.sv
// Shared widths and the stage-1 pipeline record for the floating-point adder.
package floating_pt_oper_pkg;

    localparam int unsigned DEF_MANT_W = 16;
    localparam int unsigned DEF_EXP_W  = 8;

    // Compare/align result handed to the add/normalize stage
    typedef struct packed {
        logic                  valid;
        logic                  sign;
        logic                  sub;
        logic [DEF_EXP_W-1:0]  expo;
        logic [DEF_MANT_W-1:0] mant_big;
        logic [DEF_MANT_W-1:0] mant_aln;
    } stage1_t;

endpackage

// File: rtl/floating_pt_oper_lzc.sv
// Leading-zero counter; returns W for an all-zero vector.
module fp_lzc #(
    parameter int unsigned W = 16,
    localparam int unsigned CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  vec,
    output logic [CW-1:0] count_c
);

    // Ascending scan so the most significant set bit wins
    always_comb begin
        count_c = CW'(W);
        for (int i = 0; i < W; i++) begin
            if (vec[i]) begin
                count_c = CW'(W - 1 - 32'(i));
            end
        end
    end

endmodule

// File: rtl/floating_pt_oper.sv
// Two-stage signed adder for (-1)^s * m * 2^e operands: compare/align, then add/normalize.
module floating_pt_oper
    import floating_pt_oper_pkg::*;
#(
    parameter int unsigned MANT_W = DEF_MANT_W,
    parameter int unsigned EXP_W  = DEF_EXP_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [MANT_W-1:0] a,
    input  logic              sign1,
    input  logic [EXP_W-1:0]  a1,
    input  logic [MANT_W-1:0] b,
    input  logic              sign2,
    input  logic [EXP_W-1:0]  b1,
    output logic [MANT_W-1:0] aout,
    output logic              signout,
    output logic [EXP_W-1:0]  expout,
    output logic              out_valid
);

    localparam int unsigned LZ_W = $clog2(MANT_W + 1);
    localparam int unsigned CW   = (EXP_W > LZ_W) ? EXP_W : LZ_W;
    localparam logic [EXP_W-1:0] EXP_MAX = '1;

    stage1_t s1_d;
    stage1_t s1_q;

    logic              a_larger_c;
    logic [EXP_W-1:0]  diff_c;
    logic [MANT_W-1:0] mant_small_c;

    logic [MANT_W:0]   mag_c;
    logic              rsign_c;
    logic [MANT_W-1:0] lo_c;
    logic [LZ_W-1:0]   lz_c;
    logic [CW-1:0]     shift_c;

    logic [MANT_W-1:0] aout_d;
    logic              sign_d;
    logic [EXP_W-1:0]  exp_d;

    // Stage 1: pick the larger operand and align the other to its exponent
    always_comb begin
        s1_d          = '0;
        a_larger_c    = (a1 > b1) || ((a1 == b1) && (a >= b));
        mant_small_c  = a_larger_c ? b : a;
        diff_c        = a_larger_c ? (a1 - b1) : (b1 - a1);
        s1_d.valid    = in_valid;
        s1_d.sign     = a_larger_c ? sign1 : sign2;
        s1_d.sub      = sign1 ^ sign2;
        s1_d.expo     = a_larger_c ? a1 : b1;
        s1_d.mant_big = a_larger_c ? a : b;
        s1_d.mant_aln = (32'(diff_c) >= MANT_W) ? '0 : (mant_small_c >> diff_c);
    end

    // Magnitude add/subtract; an aligned mantissa can exceed an unnormalized larger one
    always_comb begin
        rsign_c = s1_q.sign;
        if (!s1_q.sub) begin
            mag_c = {1'b0, s1_q.mant_big} + {1'b0, s1_q.mant_aln};
        end else if (s1_q.mant_aln > s1_q.mant_big) begin
            mag_c   = {1'b0, s1_q.mant_aln - s1_q.mant_big};
            rsign_c = ~s1_q.sign;
        end else begin
            mag_c = {1'b0, s1_q.mant_big - s1_q.mant_aln};
        end
    end

    assign lo_c = mag_c[MANT_W-1:0];

    fp_lzc #(.W(MANT_W)) u_lzc (
        .vec     (lo_c),
        .count_c (lz_c)
    );

    // Stage 2 normalize: carry shifts right, otherwise shift left bounded by the exponent
    always_comb begin
        shift_c = (CW'(lz_c) < CW'(s1_q.expo)) ? CW'(lz_c) : CW'(s1_q.expo);
        aout_d  = '0;
        sign_d  = 1'b0;
        exp_d   = '0;
        if (mag_c[MANT_W]) begin
            sign_d = rsign_c;
            if (s1_q.expo == EXP_MAX) begin
                aout_d = '1;
                exp_d  = EXP_MAX;
            end else begin
                aout_d = mag_c[MANT_W:1];
                exp_d  = s1_q.expo + EXP_W'(1);
            end
        end else if (lo_c != '0) begin
            sign_d = rsign_c;
            aout_d = lo_c << shift_c;
            exp_d  = s1_q.expo - EXP_W'(shift_c);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q      <= '0;
            out_valid <= 1'b0;
            aout      <= '0;
            signout   <= 1'b0;
            expout    <= '0;
        end else begin
            s1_q      <= s1_d;
            out_valid <= s1_q.valid;
            if (s1_q.valid) begin
                aout    <= aout_d;
                signout <= sign_d;
                expout  <= exp_d;
            end
        end
    end

endmodule

// File: tb/tb_floating_pt_oper.sv
// Bench for floating_pt_oper: directed vectors, randomized streams against a value model, reset mid-stream.
module tb_floating_pt_oper;

    localparam int unsigned MW = 16;
    localparam int unsigned EW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          in_valid = 1'b0;
    logic [MW-1:0] a = '0;
    logic          sign1 = 1'b0;
    logic [EW-1:0] a1 = '0;
    logic [MW-1:0] b = '0;
    logic          sign2 = 1'b0;
    logic [EW-1:0] b1 = '0;
    logic [MW-1:0] aout;
    logic          signout;
    logic [EW-1:0] expout;
    logic          out_valid;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic          v;
        logic          s;
        logic [EW-1:0] e;
        logic [MW-1:0] m;
    } res_t;

    typedef struct packed {
        logic [MW-1:0] ma;
        logic          sa;
        logic [EW-1:0] ea;
        logic [MW-1:0] mb;
        logic          sb;
        logic [EW-1:0] eb;
        res_t          r;
    } vec_t;

    res_t hold_ref = '0;

    floating_pt_oper #(.MANT_W(MW), .EXP_W(EW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .sign1     (sign1),
        .a1        (a1),
        .b         (b),
        .sign2     (sign2),
        .b1        (b1),
        .aout      (aout),
        .signout   (signout),
        .expout    (expout),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    function automatic res_t obs();
        return {out_valid, signout, expout, aout};
    endfunction

    // Value-level model: align, signed integer sum, then normalize by loop
    function automatic res_t model(input logic [MW-1:0] ma, input logic sa, input logic [EW-1:0] ea,
                                   input logic [MW-1:0] mb, input logic sb, input logic [EW-1:0] eb);
        res_t   r;
        longint bm, sm, al, v, mag;
        int     be, se, d;
        logic   bs, ss, a_big;
        a_big = (ea > eb) || ((ea == eb) && (ma >= mb));
        bm = a_big ? longint'(ma) : longint'(mb);
        sm = a_big ? longint'(mb) : longint'(ma);
        be = a_big ? int'(ea) : int'(eb);
        se = a_big ? int'(eb) : int'(ea);
        bs = a_big ? sa : sb;
        ss = a_big ? sb : sa;
        d  = be - se;
        al = (d >= int'(MW)) ? 0 : (sm >> d);
        v  = (bs ? -bm : bm) + (ss ? -al : al);
        r = '0;
        r.v = 1'b1;
        if (v == 0) return r;
        r.s = (v < 0);
        mag = r.s ? -v : v;
        if (mag >= (longint'(1) << MW)) begin
            if (be == (1 << EW) - 1) mag = (longint'(1) << MW) - 1;
            else begin
                mag = mag >> 1;
                be++;
            end
        end else begin
            while (mag < (longint'(1) << (MW - 1)) && be > 0) begin
                mag = mag << 1;
                be--;
            end
        end
        r.e = EW'(be);
        r.m = MW'(mag);
        return r;
    endfunction

    task automatic drive(input logic v, input logic [MW-1:0] ma, input logic sa, input logic [EW-1:0] ea,
                         input logic [MW-1:0] mb, input logic sb, input logic [EW-1:0] eb);
        in_valid = v;
        a = ma; sign1 = sa; a1 = ea;
        b = mb; sign2 = sb; b1 = eb;
    endtask

    task automatic rand_ops(output logic [MW-1:0] ma, output logic sa, output logic [EW-1:0] ea,
                            output logic [MW-1:0] mb, output logic sb, output logic [EW-1:0] eb);
        ea = EW'($urandom);
        eb = ($urandom_range(0, 3) == 0) ? EW'($urandom) : EW'(ea + EW'($urandom_range(0, 4)));
        ma = ($urandom_range(0, 3) == 0) ? MW'($urandom_range(0, 31)) : MW'($urandom);
        mb = ($urandom_range(0, 3) == 0) ? MW'($urandom_range(0, 31)) : MW'($urandom);
        sa = 1'($urandom);
        sb = 1'($urandom);
        if ($urandom_range(0, 15) == 0) begin
            ea = '1;
            eb = '1;
        end
        if ($urandom_range(0, 9) == 0) begin
            mb = ma;
            eb = ea;
            sb = ~sa;
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (obs() !== res_t'(0)) begin
            n_err++;
            $display("FAIL reset_async: got %h expected %h", obs(), res_t'(0));
        end
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (obs() !== res_t'(0)) begin
            n_err++;
            $display("FAIL reset_held: got %h expected %h", obs(), res_t'(0));
        end
        rst_n = 1'b1;
        hold_ref = '0;
    endtask

    task automatic test_directed();
        vec_t vecs[10];
        res_t exp_r;
        vecs[0] = '{16'h0000, 1'b0, 8'd17,  16'h0000, 1'b0, 8'd11,  '{1'b1, 1'b0, 8'd0,   16'h0000}};
        vecs[1] = '{16'h0001, 1'b0, 8'd17,  16'h0000, 1'b0, 8'd11,  '{1'b1, 1'b0, 8'd2,   16'h8000}};
        vecs[2] = '{16'h030F, 1'b0, 8'd9,   16'h000F, 1'b0, 8'd11,  '{1'b1, 1'b0, 8'd3,   16'hD200}};
        vecs[3] = '{16'h000B, 1'b0, 8'd11,  16'h0007, 1'b0, 8'd11,  '{1'b1, 1'b0, 8'd0,   16'h9000}};
        vecs[4] = '{16'hFFFF, 1'b0, 8'd5,   16'h0001, 1'b0, 8'd5,   '{1'b1, 1'b0, 8'd6,   16'h8000}};
        vecs[5] = '{16'hFFFF, 1'b0, 8'd255, 16'h0001, 1'b0, 8'd255, '{1'b1, 1'b0, 8'd255, 16'hFFFF}};
        vecs[6] = '{16'h0010, 1'b1, 8'd4,   16'h0004, 1'b0, 8'd4,   '{1'b1, 1'b1, 8'd0,   16'h00C0}};
        vecs[7] = '{16'h0005, 1'b0, 8'd3,   16'h0005, 1'b1, 8'd3,   '{1'b1, 1'b0, 8'd0,   16'h0000}};
        vecs[8] = '{16'h8000, 1'b0, 8'd20,  16'hFFFF, 1'b0, 8'd4,   '{1'b1, 1'b0, 8'd20,  16'h8000}};
        vecs[9] = '{16'h0100, 1'b0, 8'd10,  16'h0200, 1'b1, 8'd10,  '{1'b1, 1'b1, 8'd3,   16'h8000}};
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1 drive(1'b1, vecs[i].ma, vecs[i].sa, vecs[i].ea, vecs[i].mb, vecs[i].sb, vecs[i].eb);
            @(posedge clk);
            #1 drive(1'b0, '0, 1'b0, '0, '0, 1'b0, '0);
            exp_r = {1'b0, hold_ref.s, hold_ref.e, hold_ref.m};
            n_cmp++;
            if (obs() !== exp_r) begin
                n_err++;
                $display("FAIL directed_hold[%0d]: got %h expected %h", i, obs(), exp_r);
            end
            @(posedge clk);
            #1;
            n_cmp++;
            if (obs() !== vecs[i].r) begin
                n_err++;
                $display("FAIL directed[%0d]: got %h expected %h", i, obs(), vecs[i].r);
            end
            hold_ref = vecs[i].r;
        end
    endtask

    task automatic test_random(input int n, input logic gaps);
        res_t          expq[$];
        res_t          exp_r;
        logic          v;
        logic [MW-1:0] ma, mb;
        logic          sa, sb;
        logic [EW-1:0] ea, eb;
        for (int c = 0; c < n + 2; c++) begin
            @(posedge clk);
            #1;
            if (c >= 2) begin
                exp_r = expq.pop_front();
                n_cmp++;
                if (obs() !== exp_r) begin
                    n_err++;
                    $display("FAIL random[%0d]: got %h expected %h", c - 2, obs(), exp_r);
                end
            end
            if (c < n) begin
                v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
                rand_ops(ma, sa, ea, mb, sb, eb);
                drive(v, ma, sa, ea, mb, sb, eb);
                if (v) hold_ref = model(ma, sa, ea, mb, sb, eb);
                expq.push_back(v ? hold_ref : res_t'({1'b0, hold_ref.s, hold_ref.e, hold_ref.m}));
            end else begin
                drive(1'b0, '0, 1'b0, '0, '0, 1'b0, '0);
            end
        end
    endtask

    task automatic test_back_to_back_reset();
        res_t          expq[$];
        res_t          exp_r;
        logic [MW-1:0] ma, mb;
        logic          sa, sb;
        logic [EW-1:0] ea, eb;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            if (c >= 2) begin
                exp_r = expq.pop_front();
                n_cmp++;
                if (obs() !== exp_r) begin
                    n_err++;
                    $display("FAIL b2b[%0d]: got %h expected %h", c - 2, obs(), exp_r);
                end
            end
            rand_ops(ma, sa, ea, mb, sb, eb);
            drive(c < 4, ma, sa, ea, mb, sb, eb);
            if (c < 4) expq.push_back(model(ma, sa, ea, mb, sb, eb));
        end
        // Input 3 is still in stage 1 here; reset must drop it
        rst_n = 1'b0;
        drive(1'b1, 16'h1234, 1'b0, 8'd7, 16'h0042, 1'b0, 8'd7);
        #1;
        n_cmp++;
        if (obs() !== res_t'(0)) begin
            n_err++;
            $display("FAIL b2b_reset_async: got %h expected %h", obs(), res_t'(0));
        end
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if (obs() !== res_t'(0)) begin
                n_err++;
                $display("FAIL b2b_discard[%0d]: got %h expected %h", c, obs(), res_t'(0));
            end
            if (c == 1) begin
                rst_n = 1'b1;
                drive(1'b0, '0, 1'b0, '0, '0, 1'b0, '0);
            end
        end
        rand_ops(ma, sa, ea, mb, sb, eb);
        drive(1'b1, ma, sa, ea, mb, sb, eb);
        exp_r = model(ma, sa, ea, mb, sb, eb);
        @(posedge clk);
        #1 drive(1'b0, '0, 1'b0, '0, '0, 1'b0, '0);
        n_cmp++;
        if (obs() !== res_t'(0)) begin
            n_err++;
            $display("FAIL b2b_early: got %h expected %h", obs(), res_t'(0));
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (obs() !== exp_r) begin
            n_err++;
            $display("FAIL b2b_after_reset: got %h expected %h", obs(), exp_r);
        end
        hold_ref = exp_r;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random(300, 1'b0);
        test_random(300, 1'b1);
        test_back_to_back_reset();
        test_random(100, 1'b1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
